ysyx_24100005_mem_arbiter: RTL and testbench

Shares the core's single data-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) once the core becomes multi-cycle. It accepts one request at a time from either requester and issues it to the memory side over a valid/ready handshake. It routes the memory response back to the owner. A watchdog returns an error response if memory never answers.

---
 rtl/ysyx_24100005_arb_pkg.sv | 19 +
 rtl/ysyx_24100005_arb_pick.sv | 27 ++
 rtl/ysyx_24100005_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_arb_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
// Round-robin arbitration is enabled by YSYX_24100005_ARB_RR_EN.
package ysyx_24100005_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MASK_W     = 8;
endpackage

// File: rtl/ysyx_24100005_arb_pick.sv
// Winner selection between IFU and LSU requests.
// YSYX_24100005_ARB_RR_EN selects round-robin, otherwise LSU priority.
module ysyx_24100005_arb_pick
  import ysyx_24100005_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_e last_owner,
  output logic   grant,
  output owner_e winner
);
  assign grant = ifu_valid | lsu_valid;

`ifdef YSYX_24100005_ARB_RR_EN
  always_comb begin
    winner = OWN_LSU;
    if (ifu_valid && lsu_valid)
      winner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
    else if (ifu_valid)
      winner = OWN_IFU;
  end
`else
  logic unused_last;
  assign unused_last = last_owner;
  assign winner = lsu_valid ? OWN_LSU : OWN_IFU;
`endif
endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one data-memory port between IFU and LSU, with a watchdog.
// Round-robin arbitration is enabled by YSYX_24100005_ARB_RR_EN.
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state;
  owner_e            owner;
  owner_e            last_owner;
  owner_e            winner;
  logic              grant;
  logic [CW-1:0]     cnt;
  logic              tmo;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  ysyx_24100005_arb_pick u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .last_owner(last_owner),
    .grant     (grant),
    .winner    (winner)
  );

  // cnt counts cycles since ISSUE entry; fires on the TIMEOUT-th cycle
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IFU;
      last_owner <= OWN_LSU;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (grant) begin
          owner      <= winner;
          last_owner <= winner;
          cnt        <= '0;
          state      <= ISSUE;
          if (winner == OWN_LSU) begin
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wmask;
          end else begin
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid) begin
            data_q <= wen_q ? '0 : mem_resp_rdata;
            err_q  <= 1'b0;
            state  <= RESP;
          end else if (tmo) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_idle, in_issue, in_resp;
  assign in_idle  = !rst && (state == IDLE);
  assign in_issue = !rst && (state == ISSUE);
  assign in_resp  = !rst && (state == RESP);

  assign ifu_req_ready = in_idle && grant && (winner == OWN_IFU);
  assign lsu_req_ready = in_idle && grant && (winner == OWN_LSU);

  assign ifu_resp_valid = in_resp && (owner == OWN_IFU);
  assign ifu_resp_rdata = ifu_resp_valid ? data_q : '0;
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_valid = in_resp && (owner == OWN_LSU);
  assign lsu_resp_rdata = lsu_resp_valid ? data_q : '0;
  assign lsu_resp_err   = lsu_resp_valid && err_q;

  assign mem_req_valid = in_issue;
  assign mem_req_addr  = in_issue ? addr_q : '0;
  assign mem_req_wen   = in_issue && wen_q;
  assign mem_req_wdata = in_issue ? wdata_q : '0;
  assign mem_req_wmask = in_issue ? wmask_q : '0;
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Self-checking bench: transaction-level model plus directed literal checks.
// Honors YSYX_24100005_ARB_RR_EN for the arbitration expectations.
module tb_ysyx_24100005_mem_arbiter;
  localparam int TO   = 6;
  localparam int TO_S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid, lsu_req_valid, lsu_req_wen;
  logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [31:0] ifu_resp_rdata, lsu_resp_rdata;
  logic        mem_req_valid, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;

  logic        s_ifu_req_ready, s_ifu_resp_valid, s_ifu_resp_err;
  logic        s_lsu_req_ready, s_lsu_resp_valid, s_lsu_resp_err;
  logic [31:0] s_ifu_resp_rdata, s_lsu_resp_rdata;
  logic        s_mem_req_valid, s_mem_req_wen;
  logic [31:0] s_mem_req_addr, s_mem_req_wdata;
  logic [7:0]  s_mem_req_wmask;
  logic        unused_s;
  assign unused_s = ^{s_ifu_req_ready, s_lsu_req_ready, s_lsu_resp_valid,
                      s_lsu_resp_err, s_lsu_resp_rdata, s_mem_req_wen,
                      s_mem_req_addr, s_mem_req_wdata, s_mem_req_wmask};

  ysyx_24100005_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  ysyx_24100005_mem_arbiter #(.TIMEOUT(TO_S)) dut_s (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(s_ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(s_ifu_resp_valid),
    .ifu_resp_rdata(s_ifu_resp_rdata), .ifu_resp_err(s_ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(s_lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(s_lsu_resp_valid), .lsu_resp_rdata(s_lsu_resp_rdata),
    .lsu_resp_err(s_lsu_resp_err),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(s_mem_req_addr), .mem_req_wen(s_mem_req_wen),
    .mem_req_wdata(s_mem_req_wdata), .mem_req_wmask(s_mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction model: one outstanding request, aged from ISSUE entry
  bit          m_busy, m_acc, m_done, m_err, m_own, m_wen;
  bit          m_last = 1'b1;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_data;
  logic [7:0]  m_mask;

  function automatic bit pick_lsu();
`ifdef YSYX_24100005_ARB_RR_EN
    if (ifu_req_valid && lsu_req_valid) return !m_last;
`endif
    return lsu_req_valid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_last <= 1'b1;
    end else if (m_done) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (!m_acc && m_age == TO - 1) begin
        m_done <= 1'b1; m_err <= 1'b1; m_data <= '0;
      end else if (!m_acc) begin
        if (mem_req_ready) m_acc <= 1'b1;
      end else if (mem_resp_valid) begin
        m_done <= 1'b1; m_err <= 1'b0;
        m_data <= m_wen ? 32'h0 : mem_resp_rdata;
      end else if (m_age == TO - 1) begin
        m_done <= 1'b1; m_err <= 1'b1; m_data <= '0;
      end
    end else if (ifu_req_valid || lsu_req_valid) begin
      m_own  <= pick_lsu();
      m_last <= pick_lsu();
      m_busy <= 1'b1;
      m_acc  <= 1'b0;
      m_age  <= 0;
      m_addr  <= pick_lsu() ? lsu_req_addr : ifu_req_addr;
      m_wen   <= pick_lsu() ? lsu_req_wen : 1'b0;
      m_wdata <= pick_lsu() ? lsu_req_wdata : 32'h0;
      m_mask  <= pick_lsu() ? lsu_req_wmask : 8'h0;
    end
  end

  function automatic logic [143:0] exp_out();
    bit ir, lr, iv, ie, lv, le, mv, mw;
    logic [31:0] id, ld, ma, md;
    logic [7:0]  mm;
    {ir, lr, iv, ie, lv, le, mv, mw} = '0;
    {id, ld, ma, md, mm} = '0;
    if (!rst) begin
      if (!m_busy) begin
        if (ifu_req_valid || lsu_req_valid) begin
          if (pick_lsu()) lr = 1'b1;
          else ir = 1'b1;
        end
      end else if (m_done) begin
        if (m_own) begin lv = 1'b1; ld = m_data; le = m_err; end
        else begin iv = 1'b1; id = m_data; ie = m_err; end
      end else if (!m_acc) begin
        mv = 1'b1; ma = m_addr; mw = m_wen; md = m_wdata; mm = m_mask;
      end
    end
    return {ir, lr, iv, id, ie, lv, ld, le, mv, ma, mw, md, mm};
  endfunction

  logic [143:0] act;
  assign act = {ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                ifu_resp_rdata, ifu_resp_err, lsu_resp_valid,
                lsu_resp_rdata, lsu_resp_err, mem_req_valid,
                mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};

  initial forever begin
    logic [143:0] e;
    @(negedge clk);
    e = exp_out();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL model_outputs t=%0t act=%h exp=%h", $time, act, e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, a, e);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nx();
    rst = 1'b0;
  endtask

  bit ifu_first;

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 8'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ifu_ready", 32'(ifu_req_ready), 32'h0);
      chk("rst_mem_valid", 32'(mem_req_valid), 32'h0);
    end
    nx();
    rst = 1'b0; ifu_req_valid = 1'b0;
    nx();

    // IFU-only fetch
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    @(negedge clk);
    chk("ifu_ready", 32'(ifu_req_ready), 32'h1);
    nx(); ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("ifu_mem_addr", mem_req_addr, 32'h8000_0000);
    chk("ifu_mem_wmask", 32'(mem_req_wmask), 32'h0);
    nx(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0010_0093;
    nx(); mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'h1);
    chk("ifu_resp_rdata", ifu_resp_rdata, 32'h0010_0093);
    chk("ifu_resp_err", 32'(ifu_resp_err), 32'h0);
    chk("ifu_lsu_quiet", 32'(lsu_resp_valid), 32'h0);
    nx();

    // LSU store
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    @(negedge clk);
    chk("st_ready", 32'(lsu_req_ready), 32'h1);
    nx(); lsu_req_valid = 1'b0;
    @(negedge clk);
    chk("st_addr", mem_req_addr, 32'h8000_0100);
    chk("st_wen", 32'(mem_req_wen), 32'h1);
    chk("st_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    chk("st_wmask", 32'(mem_req_wmask), 32'h0F);
    nx(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    nx(); mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("st_resp_valid", 32'(lsu_resp_valid), 32'h1);
    chk("st_resp_rdata", lsu_resp_rdata, 32'h0);
    chk("st_resp_err", 32'(lsu_resp_err), 32'h0);
    nx();

    // Simultaneous requests right after reset
    do_reset();
`ifdef YSYX_24100005_ARB_RR_EN
    ifu_first = 1'b1;
`else
    ifu_first = 1'b0;
`endif
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0200;
    lsu_req_wen = 1'b0; lsu_req_wdata = 32'h0; lsu_req_wmask = 8'hFF;
    @(negedge clk);
    chk("both_ifu_ready", 32'(ifu_req_ready), 32'(ifu_first));
    chk("both_lsu_ready", 32'(lsu_req_ready), 32'(!ifu_first));
    nx();
    if (ifu_first) ifu_req_valid = 1'b0;
    else lsu_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("loser_held", 32'(ifu_first ? lsu_req_ready : ifu_req_ready), 32'h0);
      nx();
      mem_resp_valid = (i == 0); mem_resp_rdata = 32'hAAAA_0001;
    end
    @(negedge clk);
    chk("loser_ready", 32'(ifu_first ? lsu_req_ready : ifu_req_ready), 32'h1);
    nx(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    chk("loser_addr", mem_req_addr, ifu_first ? 32'h8000_0200 : 32'h8000_0004);
    nx(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBBBB_0002;
    nx(); mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("loser_rdata", ifu_first ? lsu_resp_rdata : ifu_resp_rdata, 32'hBBBB_0002);
    nx();

    // Memory stalls three cycles
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0300; lsu_req_wmask = 8'hFF;
    mem_req_ready = 1'b0;
    nx(); lsu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(mem_req_valid), 32'h1);
      chk("stall_addr", mem_req_addr, 32'h8000_0300);
      nx();
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    nx(); mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stall_rdata", lsu_resp_rdata, 32'hCAFE_F00D);
    nx();

    // Memory never answers: watchdog on both instances
    do_reset();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
    nx(); ifu_req_valid = 1'b0;
    nx(); nx(); nx();
    @(negedge clk);
    chk("tmo4_early", 32'(s_ifu_resp_valid), 32'h0);
    nx();
    @(negedge clk);
    chk("tmo4_valid", 32'(s_ifu_resp_valid), 32'h1);
    chk("tmo4_err", 32'(s_ifu_resp_err), 32'h1);
    chk("tmo4_rdata", s_ifu_resp_rdata, 32'h0);
    nx(); nx();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0055;
    @(negedge clk);
    chk("tmo6_err", 32'(ifu_resp_err), 32'h1);
    nx(); mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("late_resp_s", 32'(s_ifu_resp_valid), 32'h0);
    chk("late_resp", 32'(ifu_resp_valid), 32'h0);
    nx();

    // Reset while waiting for memory
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0400;
    nx(); lsu_req_valid = 1'b0;
    nx(); rst = 1'b1;
    nx(); rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_valid", 32'(mem_req_valid), 32'h0);
    nx(); mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0077;
    nx(); mem_resp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(lsu_resp_valid), 32'h0);
      nx();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
